// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int          DIGIT_W     = 4;
    localparam logic [3:0]  CORR_THRESH = 4'd8;
    localparam logic [3:0]  CORR_SUB    = 4'd3;
    localparam int          BYTE_MAX    = 255;

endpackage

// File: rtl/sub_3_correct.sv
// Per-digit correction step of reverse double-dabble: after a right shift,
// a BCD digit field holding 8 or more has borrowed a "10" worth of weight
// from the digit above, so 3 is removed to restore a valid BCD digit.
module sub_3_correct
    import bcd2bin_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    // Subtract 3 from any digit that has reached the correction threshold
    always_comb begin
        if (digit_in >= CORR_THRESH) begin
            digit_out = digit_in - CORR_SUB;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional build macro: BCD2BIN_DIGIT_CHECK_EN enables rejection of BCD digits
// greater than 9, reported on err with a zero result and an immediate done.
module bcd_to_binary_seq
    import bcd2bin_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [4*DIGITS-1:0]       bcd,
    output logic                      busy,
    output logic                      done,
    output logic [BIN_W-1:0]          bin,
    output logic [7:0]                byte_out,
    output logic                      ovf,
    output logic                      err
);

    localparam int WORK_W = DIGIT_W * DIGITS + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] BYTE_MAX_W = BIN_W'(BYTE_MAX);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [WORK_W-1:0]      work_q, work_d;
    logic [BIN_W-1:0]       bin_q, bin_d;
    logic [7:0]             byte_q, byte_d;
    logic                   ovf_q, ovf_d;
    logic                   err_d;

    logic [WORK_W-1:0]      shifted;
    logic [WORK_W-1:0]      work_step;
    logic [DIGIT_W*DIGITS-1:0] corrected;
    logic                   accept;
    logic                   last_shift;
    logic                   bad_digit;

    // A start request is only honoured while not converting
    assign accept     = start && (state_q == IDLE || state_q == DONE);
    assign last_shift = (state_q == SHIFT) && (count_q == CNT_W'(1));

    // One algorithm step: shift right, then correct every digit field
    assign shifted = work_q >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        sub_3_correct u_corr (
            .digit_in  (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .digit_out (corrected[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign work_step = {corrected, shifted[BIN_W-1:0]};

`ifdef BCD2BIN_DIGIT_CHECK_EN
    // Flag any input digit outside 0..9 so the conversion can be skipped
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*DIGIT_W +: DIGIT_W] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end
`else
    assign bad_digit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: an invalid input jumps straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bad_digit ? DONE : SHIFT;
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    state_d = accept ? (bad_digit ? DONE : SHIFT) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: result registers move only when DONE is entered
    always_comb begin
        work_d  = work_q;
        count_d = count_q;
        bin_d   = bin_q;
        byte_d  = byte_q;
        ovf_d   = ovf_q;
        err_d   = 1'b0;
        if (accept) begin
            work_d  = {bcd, {BIN_W{1'b0}}};
            count_d = CNT_W'(BIN_W);
            if (bad_digit) begin
                count_d = '0;
                bin_d   = '0;
                byte_d  = '0;
                ovf_d   = 1'b0;
                err_d   = 1'b1;
            end
        end else if (state_q == SHIFT) begin
            work_d  = work_step;
            count_d = count_q - CNT_W'(1);
            if (last_shift) begin
                bin_d  = work_step[BIN_W-1:0];
                byte_d = work_step[7:0];
                ovf_d  = work_step[BIN_W-1:0] > BYTE_MAX_W;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q  <= '0;
            count_q <= '0;
            bin_q   <= '0;
            byte_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            work_q  <= work_d;
            count_q <= count_d;
            bin_q   <= bin_d;
            byte_q  <= byte_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_q;

    // Error flag follows each accepted start and the final shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept || last_shift) begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = err_d;
    assign err = 1'b0;
`endif

    assign bin      = bin_q;
    assign byte_out = byte_q;
    assign ovf      = ovf_q;

endmodule
